pong_engine: RTL
================

Name: pong_engine

Overview:
Parametrised Pong game engine, successor to the fixed 800x600 controller. It adds a serve delay, per-side AI paddles, ball speed-up on hits, a configurable win score, and clean signed collision arithmetic.
- Sits between the input-debounce logic and the VGA renderer/score display.
- Advances game physics once per `tick` (frame strobe).

Parameters:
SCREEN_W, 800, playfield width in pixels
SCREEN_H, 600, playfield height in pixels
COORD_W, 10, output coordinate width (must hold SCREEN_W-1 and SCREEN_H-1)
PADDLE_H, 32, paddle height
PADDLE_D, 8, paddle depth (x extent)
PADDLE_X, 16, left paddle left edge; right paddle left edge = SCREEN_W-PADDLE_X-PADDLE_D
PADDLE_V, 5, paddle pixels per tick
BALL_S, 4, ball square size
BALL_V0, 4, serve speed per axis
BALL_VMAX, 12, speed ceiling
WIN_SCORE, 11, points to win (≤ 2^SCORE_W-1)
SCORE_W, 4, score width
SERVE_TICKS, 60, ticks between point and ball launch
AI_DEADBAND, 4, AI tolerance in pixels

Ports:
clock  in  1  system clock
reset  in  1  synchronous, active-high
tick  in  1  one-cycle frame strobe; physics advance only when high
start  in  1  start/resume/acknowledge
escape  in  1  pause request
left_up, left_down, right_up, right_down  in  1 each  human paddle controls
ai_left, ai_right  in  1 each  1 = side driven by AI; human inputs for that side are ignored
ball_x, ball_y  out  COORD_W  ball top-left corner
left_paddle_y, right_paddle_y  out  COORD_W  paddle top edges
left_score, right_score  out  SCORE_W  scores
game_state  out  3  IDLE=0, SERVE=1, PLAY=2, PAUSE=3, OVER=4
winner  out  1  0 = left, 1 = right; valid in OVER
hit_pulse  out  1  one cycle on a paddle hit
point_pulse  out  1  one cycle on a point scored

Behaviour:
- Reset values (applied on the next edge, including mid-game):
  - ball = ((SCREEN_W-BALL_S)/2, (SCREEN_H-BALL_S)/2) = (398, 298)
  - both paddles = (SCREEN_H-PADDLE_H)/2 = 284
  - scores 0, state IDLE, winner 0, pulses 0
  - speed = BALL_V0, vx = +, vy = +, serve counter 0
- FSM; non-tick transitions are evaluated every cycle:
  - IDLE: start → SERVE. Clear scores, centre ball, load counter = SERVE_TICKS.
  - SERVE: counter decrements on each tick; tick with counter == 1 (or 0) → PLAY.
  - PLAY: physics on tick.
  - SERVE/PLAY: escape → PAUSE and remember the prior state. escape has priority over a same-cycle point.
  - PAUSE: start → remembered state; all positions and the counter are frozen.
  - OVER: start → IDLE.
- Internal arithmetic is signed, COORD_W+2 bits. Outputs are always within range (never wrapped).
- Paddles move on tick in SERVE and PLAY.
  - Human side: up XOR down gives ∓PADDLE_V; both or neither gives no motion.
  - AI side: compare ball centre with paddle centre. Move up if ball < paddle−AI_DEADBAND, down if ball > paddle+AI_DEADBAND, else hold.
  - Result is clamped to [0, SCREEN_H−PADDLE_H].
- Ball (PLAY, tick), with nx = x ± speed and ny = y ± speed:
  - Walls:
    - ny < 0 → y = −ny, vy = +.
    - ny > SCREEN_H−BALL_S → y = 2(SCREEN_H−BALL_S)−ny, vy = −.
  - Left paddle hit: vx = −, nx ≤ PADDLE_X+PADDLE_D, nx+BALL_S ≥ PADDLE_X, and y-overlap with the current paddle y (ny+BALL_S ≥ py and ny ≤ py+PADDLE_H).
    - Set x = PADDLE_X+PADDLE_D, vx = +, speed = min(speed+1, BALL_VMAX), hit_pulse.
  - Right paddle hit: mirror of left; x = right edge − BALL_S, vx = −.
  - Goals:
    - nx < 0 with no hit → right scores.
    - nx > SCREEN_W−BALL_S with no hit → left scores.
  - Priority: paddle hit > goal. A wall reflection is applied independently on the y axis in the same tick.
- On a point:
  - Scorer's score +1, point_pulse.
  - Ball centred, speed = BALL_V0, vx toward the conceding side, vy toggles from its previous value.
  - If new score == WIN_SCORE → OVER with winner set. Else → SERVE with counter reloaded.
- Scores saturate; they never wrap.
- No ball motion in IDLE/SERVE/PAUSE/OVER.
- Latency: all outputs are registered; an effect is visible the cycle after the tick.

Decomposition:
- pong_pkg holds:
  - the state enum and encoding
  - default geometry constants
  - the helper function clamp()
- Sub-module pong_paddle is instantiated twice. It contains the human/AI select, step and clamp, with parameters PADDLE_H, PADDLE_V, SCREEN_H, AI_DEADBAND.

Test Plan:
- Reset, then start, then 60 ticks → state goes IDLE→SERVE→PLAY on tick 60. Ball (398,298) until PLAY, then (402,302) after the next tick.
- Wall: ball_y=2, vy=−, speed 4, tick → ball_y=2, vy=+. Ball_y=594, vy=+, tick → ball_y=594, vy=−.
- Left hit: left paddle 284, ball (26,290), vx=−, speed 4, tick → ball_x=24, vx=+, speed 5, hit_pulse for 1 cycle. At speed 12 a hit keeps speed 12.
- Goal/win:
  - Ball (2,100), vx=−, left paddle at 400, tick → right_score+1, point_pulse, SERVE, ball (398,298), speed 4, vx=−.
  - With right_score=10 → 11, OVER, winner=1. start → IDLE.
- Pause/reset: escape in PLAY → PAUSE; 10 ticks change nothing; start → PLAY. Reset asserted mid-PLAY → all reset values next cycle.
- Paddles:
  - Human, paddle=2, left_up for 1 tick → 0. Paddle=566, down → 568.
  - ai_right=1 with ball_y=100 → right paddle decreases by 5 per tick until within deadband.

Source files
------------

// File: rtl/pong_pkg.sv
// Shared types, default geometry and helpers for the Pong engine.
package pong_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_SERVE = 3'd1,
        ST_PLAY  = 3'd2,
        ST_PAUSE = 3'd3,
        ST_OVER  = 3'd4
    } game_state_t;

    localparam int DEF_SCREEN_W    = 800;
    localparam int DEF_SCREEN_H    = 600;
    localparam int DEF_COORD_W     = 10;
    localparam int DEF_PADDLE_H    = 32;
    localparam int DEF_PADDLE_D    = 8;
    localparam int DEF_PADDLE_X    = 16;
    localparam int DEF_PADDLE_V    = 5;
    localparam int DEF_BALL_S      = 4;
    localparam int DEF_BALL_V0     = 4;
    localparam int DEF_BALL_VMAX   = 12;
    localparam int DEF_WIN_SCORE   = 11;
    localparam int DEF_SCORE_W     = 4;
    localparam int DEF_SERVE_TICKS = 60;
    localparam int DEF_AI_DEADBAND = 4;

    function automatic int clamp(input int value, input int lo, input int hi);
        if (value < lo) begin
            return lo;
        end else if (value > hi) begin
            return hi;
        end
        return value;
    endfunction

endpackage

// File: rtl/pong_engine_if.sv
// Control inputs and game outputs of the Pong engine, grouped as one bus.
interface pong_engine_if
    import pong_pkg::*;
#(
    parameter int COORD_W = DEF_COORD_W,
    parameter int SCORE_W = DEF_SCORE_W
);
    logic               tick;
    logic               start;
    logic               escape;
    logic               left_up;
    logic               left_down;
    logic               right_up;
    logic               right_down;
    logic               ai_left;
    logic               ai_right;
    logic [COORD_W-1:0] ball_x;
    logic [COORD_W-1:0] ball_y;
    logic [COORD_W-1:0] left_paddle_y;
    logic [COORD_W-1:0] right_paddle_y;
    logic [SCORE_W-1:0] left_score;
    logic [SCORE_W-1:0] right_score;
    logic [2:0]         game_state;
    logic               winner;
    logic               hit_pulse;
    logic               point_pulse;

    modport master (
        output tick, start, escape, left_up, left_down, right_up, right_down,
               ai_left, ai_right,
        input  ball_x, ball_y, left_paddle_y, right_paddle_y, left_score,
               right_score, game_state, winner, hit_pulse, point_pulse
    );

    modport slave (
        input  tick, start, escape, left_up, left_down, right_up, right_down,
               ai_left, ai_right,
        output ball_x, ball_y, left_paddle_y, right_paddle_y, left_score,
               right_score, game_state, winner, hit_pulse, point_pulse
    );
endinterface

// File: rtl/pong_paddle.sv
// One paddle: human or AI steering, fixed step per enabled tick, clamped to the field.
module pong_paddle
    import pong_pkg::*;
#(
    parameter int COORD_W     = DEF_COORD_W,
    parameter int SCREEN_H    = DEF_SCREEN_H,
    parameter int PADDLE_H    = DEF_PADDLE_H,
    parameter int PADDLE_V    = DEF_PADDLE_V,
    parameter int BALL_S      = DEF_BALL_S,
    parameter int AI_DEADBAND = DEF_AI_DEADBAND
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               step_en,
    input  logic               ai_en,
    input  logic               up,
    input  logic               down,
    input  logic [COORD_W-1:0] ball_y,
    output logic [COORD_W-1:0] paddle_y
);
    localparam int CW = COORD_W + 2;
    localparam logic [COORD_W-1:0]   PADDLE_Y0 = COORD_W'((SCREEN_H - PADDLE_H) / 2);
    localparam logic signed [CW-1:0] STEP      = CW'(PADDLE_V);
    localparam logic signed [CW-1:0] HALF_BALL = CW'(BALL_S / 2);
    localparam logic signed [CW-1:0] HALF_PAD  = CW'(PADDLE_H / 2);
    localparam logic signed [CW-1:0] DEADBAND  = CW'(AI_DEADBAND);

    logic [COORD_W-1:0]   paddle_y_reg;
    logic [COORD_W-1:0]   paddle_y_next;
    logic signed [CW-1:0] pad_pos;
    logic signed [CW-1:0] ball_centre;
    logic signed [CW-1:0] pad_centre;
    logic signed [CW-1:0] target;

    always_comb begin
        pad_pos     = $signed({2'b00, paddle_y_reg});
        ball_centre = $signed({2'b00, ball_y}) + HALF_BALL;
        pad_centre  = pad_pos + HALF_PAD;
        target      = pad_pos;
        if (ai_en) begin
            if (ball_centre < pad_centre - DEADBAND) begin
                target = pad_pos - STEP;
            end else if (ball_centre > pad_centre + DEADBAND) begin
                target = pad_pos + STEP;
            end
        end else if (up ^ down) begin
            target = up ? pad_pos - STEP : pad_pos + STEP;
        end
        // Target may step past either edge; clamp before it is stored.
        paddle_y_next = COORD_W'(clamp(int'(target), 0, SCREEN_H - PADDLE_H));
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            paddle_y_reg <= PADDLE_Y0;
        end else if (step_en) begin
            paddle_y_reg <= paddle_y_next;
        end
    end

    assign paddle_y = paddle_y_reg;

endmodule

// File: rtl/pong_engine.sv
// Pong game engine: serve/play/pause/over sequencing, ball physics and scoring per frame tick.
module pong_engine
    import pong_pkg::*;
#(
    parameter int SCREEN_W    = DEF_SCREEN_W,
    parameter int SCREEN_H    = DEF_SCREEN_H,
    parameter int COORD_W     = DEF_COORD_W,
    parameter int PADDLE_H    = DEF_PADDLE_H,
    parameter int PADDLE_D    = DEF_PADDLE_D,
    parameter int PADDLE_X    = DEF_PADDLE_X,
    parameter int PADDLE_V    = DEF_PADDLE_V,
    parameter int BALL_S      = DEF_BALL_S,
    parameter int BALL_V0     = DEF_BALL_V0,
    parameter int BALL_VMAX   = DEF_BALL_VMAX,
    parameter int WIN_SCORE   = DEF_WIN_SCORE,
    parameter int SCORE_W     = DEF_SCORE_W,
    parameter int SERVE_TICKS = DEF_SERVE_TICKS,
    parameter int AI_DEADBAND = DEF_AI_DEADBAND
) (
    input  logic         clock,
    input  logic         reset,
    pong_engine_if.slave bus
);
    localparam int CW    = COORD_W + 2;
    localparam int CNT_W = $clog2(SERVE_TICKS + 1);

    localparam logic signed [CW-1:0] X_MAX      = CW'(SCREEN_W - BALL_S);
    localparam logic signed [CW-1:0] Y_MAX      = CW'(SCREEN_H - BALL_S);
    localparam logic signed [CW-1:0] Y_REFLECT  = CW'(2 * (SCREEN_H - BALL_S));
    localparam logic signed [CW-1:0] BALL_X0    = CW'((SCREEN_W - BALL_S) / 2);
    localparam logic signed [CW-1:0] BALL_Y0    = CW'((SCREEN_H - BALL_S) / 2);
    localparam logic signed [CW-1:0] BALL_SZ    = CW'(BALL_S);
    localparam logic signed [CW-1:0] PAD_H      = CW'(PADDLE_H);
    localparam logic signed [CW-1:0] LEFT_X     = CW'(PADDLE_X);
    localparam logic signed [CW-1:0] LEFT_FACE  = CW'(PADDLE_X + PADDLE_D);
    localparam logic signed [CW-1:0] RIGHT_X    = CW'(SCREEN_W - PADDLE_X - PADDLE_D);
    localparam logic signed [CW-1:0] RIGHT_BACK = CW'(SCREEN_W - PADDLE_X);
    localparam logic signed [CW-1:0] RIGHT_STOP = CW'(SCREEN_W - PADDLE_X - PADDLE_D - BALL_S);
    localparam logic signed [CW-1:0] SPEED0     = CW'(BALL_V0);
    localparam logic signed [CW-1:0] VMAX       = CW'(BALL_VMAX);
    localparam logic signed [CW-1:0] ONE        = CW'(1);
    localparam logic [SCORE_W-1:0]   WIN        = SCORE_W'(WIN_SCORE);
    localparam logic [CNT_W-1:0]     SERVE_LOAD = CNT_W'(SERVE_TICKS);

    game_state_t          state_reg;
    game_state_t          resume_reg;
    logic signed [CW-1:0] ball_x_reg;
    logic signed [CW-1:0] ball_y_reg;
    logic signed [CW-1:0] speed_reg;
    logic                 vx_reg;
    logic                 vy_reg;
    logic [CNT_W-1:0]     serve_cnt_reg;
    logic [SCORE_W-1:0]   left_score_reg;
    logic [SCORE_W-1:0]   right_score_reg;
    logic                 winner_reg;
    logic                 hit_pulse_reg;
    logic                 point_pulse_reg;

    logic [1:0]         pad_ai;
    logic [1:0]         pad_up;
    logic [1:0]         pad_down;
    logic [COORD_W-1:0] pad_y [2];
    logic               paddle_step;

    logic signed [CW-1:0] nx;
    logic signed [CW-1:0] ny;
    logic signed [CW-1:0] y_bounce;
    logic                 vy_bounce;
    logic signed [CW-1:0] left_pad;
    logic signed [CW-1:0] right_pad;
    logic signed [CW-1:0] speed_next;
    logic                 left_hit;
    logic                 right_hit;
    logic                 goal_left;
    logic                 goal_right;
    logic [SCORE_W-1:0]   left_score_next;
    logic [SCORE_W-1:0]   right_score_next;

    // Index 0 is the left paddle, index 1 the right paddle.
    assign pad_ai      = {bus.ai_right, bus.ai_left};
    assign pad_up      = {bus.right_up, bus.left_up};
    assign pad_down    = {bus.right_down, bus.left_down};
    assign paddle_step = bus.tick && !bus.escape &&
                         (state_reg == ST_SERVE || state_reg == ST_PLAY);

    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_paddle
            pong_paddle #(
                .COORD_W    (COORD_W),
                .SCREEN_H   (SCREEN_H),
                .PADDLE_H   (PADDLE_H),
                .PADDLE_V   (PADDLE_V),
                .BALL_S     (BALL_S),
                .AI_DEADBAND(AI_DEADBAND)
            ) u_paddle (
                .clock   (clock),
                .reset   (reset),
                .step_en (paddle_step),
                .ai_en   (pad_ai[gi]),
                .up      (pad_up[gi]),
                .down    (pad_down[gi]),
                .ball_y  (ball_y_reg[COORD_W-1:0]),
                .paddle_y(pad_y[gi])
            );
        end
    endgenerate

    always_comb begin
        nx        = vx_reg ? ball_x_reg + speed_reg : ball_x_reg - speed_reg;
        ny        = vy_reg ? ball_y_reg + speed_reg : ball_y_reg - speed_reg;
        y_bounce  = ny;
        vy_bounce = vy_reg;
        if (ny[CW-1]) begin
            y_bounce  = -ny;
            vy_bounce = 1'b1;
        end else if (ny > Y_MAX) begin
            y_bounce  = Y_REFLECT - ny;
            vy_bounce = 1'b0;
        end

        // Hit tests use the paddle positions from before this tick's move.
        left_pad  = $signed({2'b00, pad_y[0]});
        right_pad = $signed({2'b00, pad_y[1]});
        left_hit  = !vx_reg && (nx <= LEFT_FACE) && (nx + BALL_SZ >= LEFT_X) &&
                    (ny + BALL_SZ >= left_pad) && (ny <= left_pad + PAD_H);
        right_hit = vx_reg && (nx + BALL_SZ >= RIGHT_X) && (nx <= RIGHT_BACK) &&
                    (ny + BALL_SZ >= right_pad) && (ny <= right_pad + PAD_H);
        goal_right = nx[CW-1] && !left_hit;
        goal_left  = (nx > X_MAX) && !right_hit;

        speed_next       = (speed_reg < VMAX) ? speed_reg + ONE : VMAX;
        left_score_next  = (left_score_reg == '1) ? left_score_reg
                                                  : left_score_reg + SCORE_W'(1);
        right_score_next = (right_score_reg == '1) ? right_score_reg
                                                   : right_score_reg + SCORE_W'(1);
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_reg       <= ST_IDLE;
            resume_reg      <= ST_IDLE;
            ball_x_reg      <= BALL_X0;
            ball_y_reg      <= BALL_Y0;
            speed_reg       <= SPEED0;
            vx_reg          <= 1'b1;
            vy_reg          <= 1'b1;
            serve_cnt_reg   <= '0;
            left_score_reg  <= '0;
            right_score_reg <= '0;
            winner_reg      <= 1'b0;
            hit_pulse_reg   <= 1'b0;
            point_pulse_reg <= 1'b0;
        end else begin
            hit_pulse_reg   <= 1'b0;
            point_pulse_reg <= 1'b0;
            case (state_reg)
                ST_IDLE: begin
                    if (bus.start) begin
                        state_reg       <= ST_SERVE;
                        left_score_reg  <= '0;
                        right_score_reg <= '0;
                        ball_x_reg      <= BALL_X0;
                        ball_y_reg      <= BALL_Y0;
                        speed_reg       <= SPEED0;
                        serve_cnt_reg   <= SERVE_LOAD;
                    end
                end
                ST_SERVE: begin
                    if (bus.escape) begin
                        resume_reg <= ST_SERVE;
                        state_reg  <= ST_PAUSE;
                    end else if (bus.tick) begin
                        if (serve_cnt_reg <= CNT_W'(1)) begin
                            state_reg     <= ST_PLAY;
                            serve_cnt_reg <= '0;
                        end else begin
                            serve_cnt_reg <= serve_cnt_reg - CNT_W'(1);
                        end
                    end
                end
                ST_PLAY: begin
                    if (bus.escape) begin
                        resume_reg <= ST_PLAY;
                        state_reg  <= ST_PAUSE;
                    end else if (bus.tick) begin
                        if (goal_left || goal_right) begin
                            ball_x_reg      <= BALL_X0;
                            ball_y_reg      <= BALL_Y0;
                            speed_reg       <= SPEED0;
                            vx_reg          <= goal_left;  // serve toward the conceding side
                            vy_reg          <= ~vy_reg;
                            point_pulse_reg <= 1'b1;
                            if (goal_right) begin
                                right_score_reg <= right_score_next;
                                if (right_score_next == WIN) begin
                                    state_reg  <= ST_OVER;
                                    winner_reg <= 1'b1;
                                end else begin
                                    state_reg     <= ST_SERVE;
                                    serve_cnt_reg <= SERVE_LOAD;
                                end
                            end else begin
                                left_score_reg <= left_score_next;
                                if (left_score_next == WIN) begin
                                    state_reg  <= ST_OVER;
                                    winner_reg <= 1'b0;
                                end else begin
                                    state_reg     <= ST_SERVE;
                                    serve_cnt_reg <= SERVE_LOAD;
                                end
                            end
                        end else begin
                            ball_y_reg <= y_bounce;
                            vy_reg     <= vy_bounce;
                            if (left_hit) begin
                                ball_x_reg    <= LEFT_FACE;
                                vx_reg        <= 1'b1;
                                speed_reg     <= speed_next;
                                hit_pulse_reg <= 1'b1;
                            end else if (right_hit) begin
                                ball_x_reg    <= RIGHT_STOP;
                                vx_reg        <= 1'b0;
                                speed_reg     <= speed_next;
                                hit_pulse_reg <= 1'b1;
                            end else begin
                                ball_x_reg <= nx;
                            end
                        end
                    end
                end
                ST_PAUSE: begin
                    if (bus.start) begin
                        state_reg <= resume_reg;
                    end
                end
                ST_OVER: begin
                    if (bus.start) begin
                        state_reg <= ST_IDLE;
                    end
                end
                default: state_reg <= ST_IDLE;
            endcase
        end
    end

    assign bus.ball_x         = ball_x_reg[COORD_W-1:0];
    assign bus.ball_y         = ball_y_reg[COORD_W-1:0];
    assign bus.left_paddle_y  = pad_y[0];
    assign bus.right_paddle_y = pad_y[1];
    assign bus.left_score     = left_score_reg;
    assign bus.right_score    = right_score_reg;
    assign bus.game_state     = state_reg;
    assign bus.winner         = winner_reg;
    assign bus.hit_pulse      = hit_pulse_reg;
    assign bus.point_pulse    = point_pulse_reg;

endmodule
